// File: rtl/gfx_rom_arbiter.sv
// Four-client graphics ROM read arbiter with a one-word (32-bit) cache per client.
// Misses are fetched from the SDRAM bank as two 16-bit beats, granted round-robin.
module gfx_rom_arbiter #(
    parameter int AW = 22
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            DOWNLOADING,
    input  logic [3:0]      REQ_CS,
    input  logic [4*AW-1:0] REQ_ADDR,
    output logic [127:0]    REQ_DOUT,
    output logic [3:0]      REQ_OK,
    output logic [AW-1:0]   BA_ADDR,
    output logic            BA_RD,
    input  logic            BA_ACK,
    input  logic            BA_DOK,
    input  logic [15:0]     DATA_READ
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_BEAT0,
        ST_BEAT1
    } state_t;

    state_t state, state_nx;

    logic [3:0][AW-2:0] tag;
    logic [3:0][31:0]   data;
    logic [3:0]         valid;
    logic [3:0]         hit;
    logic [3:0]         pending;
    logic [1:0]         last_grant;
    logic [1:0]         gnt;
    logic [AW-2:0]      gnt_tag;
    logic [1:0]         pick;
    logic               pick_vld;
    logic               start;
    logic               lo_wr;
    logic               hi_wr;

    always_comb begin
        hit = '0;
        for (int i = 0; i < 4; i++)
            hit[i] = valid[i] && (tag[i] == REQ_ADDR[i*AW+1 +: AW-1]);
    end

    assign pending  = REQ_CS & ~hit;
    assign REQ_OK   = REQ_CS & hit;
    assign REQ_DOUT = data;

    // Scan downwards so the nearest client after last_grant wins.
    always_comb begin
        pick     = last_grant;
        pick_vld = 1'b0;
        for (int k = 4; k >= 1; k--) begin
            if (pending[last_grant + 2'(k)]) begin
                pick     = last_grant + 2'(k);
                pick_vld = 1'b1;
            end
        end
    end

    assign start = (state == ST_IDLE) && pick_vld && !DOWNLOADING;
    assign lo_wr = BA_DOK && ((state == ST_BEAT0) ||
                              (state == ST_REQ && BA_ACK));
    assign hi_wr = BA_DOK && (state == ST_BEAT1);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:  if (start) state_nx = ST_REQ;
            ST_REQ:   if (BA_ACK) state_nx = BA_DOK ? ST_BEAT1 : ST_BEAT0;
            ST_BEAT0: if (BA_DOK) state_nx = ST_BEAT1;
            ST_BEAT1: if (BA_DOK) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        BA_RD = (state == ST_REQ);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            tag        <= '0;
            data       <= '0;
            valid      <= '0;
            last_grant <= 2'd3;
            gnt        <= 2'd0;
            gnt_tag    <= '0;
            BA_ADDR    <= '0;
        end else begin
            if (start) begin
                gnt          <= pick;
                gnt_tag      <= REQ_ADDR[int'(pick)*AW+1 +: AW-1];
                BA_ADDR      <= {REQ_ADDR[int'(pick)*AW+1 +: AW-1], 1'b0};
                valid[pick]  <= 1'b0;
            end
            if (lo_wr)
                data[gnt][15:0] <= DATA_READ;
            if (hi_wr) begin
                data[gnt][31:16] <= DATA_READ;
                tag[gnt]         <= gnt_tag;
                valid[gnt]       <= 1'b1;
                last_grant       <= gnt;
            end
            // A download invalidates everything, including a fetch landing now.
            if (DOWNLOADING)
                valid <= '0;
        end
    end

endmodule
